seg7_monitor: RTL and testbench
===============================

SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 Parameter: STALL_LIMIT, default 16, meaning consecutive identical-digit samples before paused asserts (range 2..255).
REQ-002 clock  input  1  single clock, all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 seg  input  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high, from the decimal counter under observation.
REQ-005 digit  output  4  last legally decoded digit, 0..9.
REQ-006 digit_valid  output  1  high while in TRACK state.
REQ-007 dir_up  output  1  last accepted step was +1 mod 10.
REQ-008 dir_down  output  1  last accepted step was -1 mod 10.
REQ-009 paused  output  1  digit held for >= STALL_LIMIT consecutive samples.
REQ-010 illegal_err  output  1  one-cycle pulse on a pattern that is not a decimal glyph.
REQ-011 skip_err  output  1  one-cycle pulse on a legal digit that is neither prev, prev+1 nor prev-1 (mod 10).
REQ-012 step_count  output  8  saturating count of accepted up or down steps since reset.

Function
REQ-013 Legal glyphs SHALL be 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F; every other value SHALL be illegal.
REQ-014 seg SHALL be registered once, then decoded; every output SHALL reflect a sample taken one posedge earlier (latency 1 cycle from sample register to outputs, 2 edges from seg change).
REQ-015 FSM states SHALL be SYNC, TRACK, FAULT.
REQ-016 SYNC: legal glyph -> digit loaded, stall counter = 1, go TRACK; illegal glyph -> illegal_err pulse, go FAULT.
REQ-017 TRACK, sample == digit: stall counter increments, saturating at STALL_LIMIT; paused SHALL assert on the cycle the counter reaches STALL_LIMIT and stay high while the digit holds.
REQ-018 TRACK, sample == digit+1 mod 10 (including 9->0): digit updates, dir_up=1, dir_down=0, stall counter=1, paused=0, step_count+1.
REQ-019 TRACK, sample == digit-1 mod 10 (including 0->9): digit updates, dir_down=1, dir_up=0, stall counter=1, paused=0, step_count+1.
REQ-020 TRACK, other legal digit: skip_err pulse, digit loads the new value, dir flags cleared, stall counter=1, paused=0, go FAULT.
REQ-021 TRACK or FAULT, illegal glyph: illegal_err pulse, go FAULT; digit keeps its last legal value.
REQ-022 FAULT: digit_valid=0, paused=0, dir flags 0; first legal glyph -> load digit, stall counter=1, go TRACK with no error pulse.
REQ-023 dir_up and dir_down SHALL never both be 1.
REQ-024 step_count SHALL saturate at 255 and never wrap.
REQ-025 illegal_err and skip_err SHALL never assert in the same cycle; illegal takes precedence.

Reset
REQ-026 While reset is low, state=SYNC, sample register=7'h00, digit=0, digit_valid=0, dir_up=0, dir_down=0, paused=0, illegal_err=0, skip_err=0, step_count=0, stall counter=0, asynchronously.
REQ-027 The first sample after reset deasserts SHALL be treated as an SYNC input; reset mid-operation SHALL discard all history.

Structure
REQ-028 Package seg7_pkg SHALL hold the ten glyph constants, the FSM state encoding, and the digit width.
REQ-029 Sub-module seg7_decode (combinational: seg -> digit[3:0], legal) SHALL be the only glyph lookup in the block.

Verification
REQ-030 Reset, then glyphs 0,1,...,9,0 one per cycle -> digit_valid after the first, dir_up=1, no errors, step_count=10, final digit=0.
REQ-031 Glyphs 3,2,1,0,9 -> dir_down=1 throughout, no skip_err at 0->9, step_count=4, digit=9.
REQ-032 Glyph 5 held 20 cycles with STALL_LIMIT=16 -> paused rises on the 16th sample, stays high; then glyph 6 -> paused=0, dir_up=1.
REQ-033 Sequence 2, 7'h00, 3 -> illegal_err one pulse, digit_valid=0 for one cycle, digit stays 2, then TRACK with digit=3 and no skip_err.
REQ-034 Sequence 2, 5 -> skip_err one pulse, FAULT; next glyph 6 -> TRACK, digit=6, step_count unchanged by the skip.
REQ-035 Reset asserted mid-count at digit=7 -> all outputs zero immediately; after release, glyph 4 -> TRACK, digit=4, step_count=0.

Source files
------------

// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// Module      : seg7_pkg
// Description : Shared constants and types for the seven-segment monitor:
//               glyph patterns ({g,f,e,d,c,b,a}, active-high), digit width
//               and FSM state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package seg7_pkg;

    localparam int c_DIGIT_W = 4;
    localparam int c_SEG_W   = 7;
    localparam int c_CNT_W   = 8;

    // Decimal glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [c_SEG_W-1:0] c_GLYPH_0 = 7'h3F;
    localparam logic [c_SEG_W-1:0] c_GLYPH_1 = 7'h06;
    localparam logic [c_SEG_W-1:0] c_GLYPH_2 = 7'h5B;
    localparam logic [c_SEG_W-1:0] c_GLYPH_3 = 7'h4F;
    localparam logic [c_SEG_W-1:0] c_GLYPH_4 = 7'h66;
    localparam logic [c_SEG_W-1:0] c_GLYPH_5 = 7'h6D;
    localparam logic [c_SEG_W-1:0] c_GLYPH_6 = 7'h7D;
    localparam logic [c_SEG_W-1:0] c_GLYPH_7 = 7'h07;
    localparam logic [c_SEG_W-1:0] c_GLYPH_8 = 7'h7F;
    localparam logic [c_SEG_W-1:0] c_GLYPH_9 = 7'h6F;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_decode.sv
//------------------------------------------------------------------------------
// Module      : seg7_decode
// Description : Combinational glyph lookup: seven-segment pattern to decimal
//               digit plus a legal flag. Non-decimal patterns report 0/illegal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [c_SEG_W-1:0]   i_seg,
    output logic [c_DIGIT_W-1:0] o_digit,
    output logic                 o_legal
);

    // Table lookup; anything not in the table is flagged illegal
    always_comb begin
        o_digit = '0;
        o_legal = 1'b1;
        case (i_seg)
            c_GLYPH_0: o_digit = 4'd0;
            c_GLYPH_1: o_digit = 4'd1;
            c_GLYPH_2: o_digit = 4'd2;
            c_GLYPH_3: o_digit = 4'd3;
            c_GLYPH_4: o_digit = 4'd4;
            c_GLYPH_5: o_digit = 4'd5;
            c_GLYPH_6: o_digit = 4'd6;
            c_GLYPH_7: o_digit = 4'd7;
            c_GLYPH_8: o_digit = 4'd8;
            c_GLYPH_9: o_digit = 4'd9;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule : seg7_decode

`default_nettype wire

// File: rtl/seg7_monitor.sv
//------------------------------------------------------------------------------
// Module      : seg7_monitor
// Description : Watches a seven-segment display driven by a decimal counter.
//               Registers the pattern, decodes it, and tracks direction,
//               stalls, skipped digits and illegal glyphs. All outputs are
//               registered one cycle after the sample register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STALL_LIMIT = 16
)
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [c_SEG_W-1:0]   i_seg,
    output logic [c_DIGIT_W-1:0] o_digit,
    output logic                 o_digit_valid,
    output logic                 o_dir_up,
    output logic                 o_dir_down,
    output logic                 o_paused,
    output logic                 o_illegal_err,
    output logic                 o_skip_err,
    output logic [c_CNT_W-1:0]   o_step_count
);

    localparam logic [c_CNT_W-1:0] c_STALL_MAX = c_CNT_W'(STALL_LIMIT);
    localparam logic [c_CNT_W-1:0] c_STEP_MAX  = '1;

    // Sample register; r_sample_vld keeps the reset value of r_sample from
    // being interpreted as an illegal glyph on the first edge after reset.
    logic [c_SEG_W-1:0]   r_sample;
    logic                 r_sample_vld;

    state_t               r_state;
    logic [c_DIGIT_W-1:0] r_digit;
    logic                 r_dir_up;
    logic                 r_dir_dn;
    logic                 r_paused;
    logic                 r_ill;
    logic                 r_skip;
    logic [c_CNT_W-1:0]   r_step;
    logic [c_CNT_W-1:0]   r_stall;

    state_t               w_state_nxt;
    logic [c_DIGIT_W-1:0] w_digit_nxt;
    logic                 w_dir_up_nxt;
    logic                 w_dir_dn_nxt;
    logic                 w_paused_nxt;
    logic                 w_ill_nxt;
    logic                 w_skip_nxt;
    logic [c_CNT_W-1:0]   w_step_nxt;
    logic [c_CNT_W-1:0]   w_stall_nxt;

    logic [c_DIGIT_W-1:0] w_dec_digit;
    logic                 w_dec_legal;
    logic [c_DIGIT_W-1:0] w_digit_plus;
    logic [c_DIGIT_W-1:0] w_digit_minus;
    logic [c_CNT_W-1:0]   w_stall_inc;
    logic [c_CNT_W-1:0]   w_step_inc;

    seg7_decode u_decode (
        .i_seg   (r_sample),
        .o_digit (w_dec_digit),
        .o_legal (w_dec_legal)
    );

    // Neighbours of the current digit (mod 10) and saturating increments
    assign w_digit_plus  = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    assign w_digit_minus = (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
    assign w_stall_inc   = (r_stall < c_STALL_MAX) ? r_stall + 8'd1 : r_stall;
    assign w_step_inc    = (r_step != c_STEP_MAX) ? r_step + 8'd1 : r_step;

    // Capture the raw segment pattern every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample     <= i_seg;
            r_sample_vld <= 1'b1;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_SYNC;
            r_digit  <= '0;
            r_dir_up <= 1'b0;
            r_dir_dn <= 1'b0;
            r_paused <= 1'b0;
            r_ill    <= 1'b0;
            r_skip   <= 1'b0;
            r_step   <= '0;
            r_stall  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_digit  <= w_digit_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_dir_dn <= w_dir_dn_nxt;
            r_paused <= w_paused_nxt;
            r_ill    <= w_ill_nxt;
            r_skip   <= w_skip_nxt;
            r_step   <= w_step_nxt;
            r_stall  <= w_stall_nxt;
        end
    end

    // Next-state and output decisions for the decoded sample
    always_comb begin
        w_state_nxt  = r_state;
        w_digit_nxt  = r_digit;
        w_dir_up_nxt = r_dir_up;
        w_dir_dn_nxt = r_dir_dn;
        w_paused_nxt = r_paused;
        w_ill_nxt    = 1'b0;
        w_skip_nxt   = 1'b0;
        w_step_nxt   = r_step;
        w_stall_nxt  = r_stall;

        if (r_sample_vld) begin
            if (!w_dec_legal) begin
                // Illegal glyph wins over everything; digit keeps last legal value
                w_ill_nxt    = 1'b1;
                w_state_nxt  = ST_FAULT;
                w_dir_up_nxt = 1'b0;
                w_dir_dn_nxt = 1'b0;
                w_paused_nxt = 1'b0;
                w_stall_nxt  = '0;
            end else begin
                case (r_state)
                    ST_SYNC, ST_FAULT: begin
                        // (Re)acquire: load digit without counting a step
                        w_digit_nxt  = w_dec_digit;
                        w_stall_nxt  = 8'd1;
                        w_dir_up_nxt = 1'b0;
                        w_dir_dn_nxt = 1'b0;
                        w_paused_nxt = 1'b0;
                        w_state_nxt  = ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (w_dec_digit == r_digit) begin
                            w_stall_nxt  = w_stall_inc;
                            w_paused_nxt = (w_stall_inc == c_STALL_MAX);
                        end else if (w_dec_digit == w_digit_plus) begin
                            w_digit_nxt  = w_dec_digit;
                            w_dir_up_nxt = 1'b1;
                            w_dir_dn_nxt = 1'b0;
                            w_stall_nxt  = 8'd1;
                            w_paused_nxt = 1'b0;
                            w_step_nxt   = w_step_inc;
                        end else if (w_dec_digit == w_digit_minus) begin
                            w_digit_nxt  = w_dec_digit;
                            w_dir_up_nxt = 1'b0;
                            w_dir_dn_nxt = 1'b1;
                            w_stall_nxt  = 8'd1;
                            w_paused_nxt = 1'b0;
                            w_step_nxt   = w_step_inc;
                        end else begin
                            // Counter jumped: remember where it landed, then resync
                            w_skip_nxt   = 1'b1;
                            w_digit_nxt  = w_dec_digit;
                            w_dir_up_nxt = 1'b0;
                            w_dir_dn_nxt = 1'b0;
                            w_stall_nxt  = 8'd1;
                            w_paused_nxt = 1'b0;
                            w_state_nxt  = ST_FAULT;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign o_digit       = r_digit;
    assign o_digit_valid = (r_state == ST_TRACK);
    assign o_dir_up      = r_dir_up;
    assign o_dir_down    = r_dir_dn;
    assign o_paused      = r_paused;
    assign o_illegal_err = r_ill;
    assign o_skip_err    = r_skip;
    assign o_step_count  = r_step;

endmodule : seg7_monitor

`default_nettype wire

// File: tb/tb_seg7_monitor.sv
//------------------------------------------------------------------------------
// Module      : tb_seg7_monitor
// Description : Self-checking bench for seg7_monitor. Vector tables hold the
//               applied glyph and the expected outputs; expectations are
//               queued when a glyph is driven and compared two edges later.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h00;

    logic [3:0] o_digit;
    logic       o_digit_valid;
    logic       o_dir_up;
    logic       o_dir_down;
    logic       o_paused;
    logic       o_illegal_err;
    logic       o_skip_err;
    logic [7:0] o_step_count;

    seg7_monitor #(.STALL_LIMIT(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg         (seg),
        .o_digit       (o_digit),
        .o_digit_valid (o_digit_valid),
        .o_dir_up      (o_dir_up),
        .o_dir_down    (o_dir_down),
        .o_paused      (o_paused),
        .o_illegal_err (o_illegal_err),
        .o_skip_err    (o_skip_err),
        .o_step_count  (o_step_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] digit;
        logic       valid;
        logic       up;
        logic       dn;
        logic       paused;
        logic       ill;
        logic       skip;
        logic [7:0] step;
    } vec_t;

    typedef struct {
        int    due;
        vec_t  v;
        string name;
    } sb_t;

    sb_t        sbq[$];
    vec_t       tbl[$];
    logic [6:0] gly[10];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic [17:0] w_act;
    assign w_act = {o_digit, o_digit_valid, o_dir_up, o_dir_down, o_paused,
                    o_illegal_err, o_skip_err, o_step_count};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [6:0] s, input int d, input int va,
                                input int up, input int dn, input int pa,
                                input int il, input int sk, input int st);
        vec_t r;
        r.seg    = s;
        r.digit  = 4'(d);
        r.valid  = 1'(va);
        r.up     = 1'(up);
        r.dn     = 1'(dn);
        r.paused = 1'(pa);
        r.ill    = 1'(il);
        r.skip   = 1'(sk);
        r.step   = 8'(st);
        return r;
    endfunction

    function automatic logic [17:0] exp_of(input vec_t v);
        return {v.digit, v.valid, v.up, v.dn, v.paused, v.ill, v.skip, v.step};
    endfunction

    task automatic check_val(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got digit=%0d valid=%b up=%b dn=%b paused=%b ill=%b skip=%b step=%0d; want digit=%0d valid=%b up=%b dn=%b paused=%b ill=%b skip=%b step=%0d",
                     nm, act[17:14], act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[17:14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Compare every expectation whose output cycle has arrived
    task automatic check_due();
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            check_val(e.name, w_act, exp_of(e.v));
        end
    endtask

    // Drive one glyph on the falling edge; its result is visible two edges later
    task automatic tick(input vec_t v, input string nm);
        @(negedge clk);
        check_due();
        seg = v.seg;
        sbq.push_back('{cyc + 2, v, nm});
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++)
            tick(tbl[i], $sformatf("%s[%0d]", nm, i));
    endtask

    task automatic drain();
        repeat (3) begin
            @(negedge clk);
            check_due();
        end
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations never compared, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Assert reset between edges, check outputs clear at once, then release
    task automatic do_reset(input string nm);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_val(nm, w_act, 18'h0);
        sbq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        gly[0] = 7'h3F; gly[1] = 7'h06; gly[2] = 7'h5B; gly[3] = 7'h4F; gly[4] = 7'h66;
        gly[5] = 7'h6D; gly[6] = 7'h7D; gly[7] = 7'h07; gly[8] = 7'h7F; gly[9] = 7'h6F;

        repeat (2) @(posedge clk);

        // Count up 0..9,0 including the 9->0 wrap
        do_reset("reset_up");
        tbl.delete();
        tbl.push_back(mk(gly[0], 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(gly[k % 10], k % 10, 1, 1, 0, 0, 0, 0, k));
        run_table("count_up");
        drain();

        // Count down 3..0,9 including the 0->9 wrap
        do_reset("reset_down");
        tbl.delete();
        tbl.push_back(mk(gly[3], 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[2], 2, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(gly[1], 1, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(gly[0], 0, 1, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(gly[9], 9, 1, 0, 1, 0, 0, 0, 4));
        run_table("count_down");
        drain();

        // Stall: paused rises on the 16th identical sample, clears on a step
        do_reset("reset_stall");
        tbl.delete();
        for (int j = 1; j <= 20; j++)
            tbl.push_back(mk(gly[5], 5, 1, 0, 0, (j >= 16) ? 1 : 0, 0, 0, 0));
        tbl.push_back(mk(gly[6], 6, 1, 1, 0, 0, 0, 0, 1));
        run_table("stall");
        drain();

        // Illegal glyph: one pulse, digit holds, resync without error or step
        do_reset("reset_illegal");
        tbl.delete();
        tbl.push_back(mk(gly[2], 2, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'h00, 2, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(gly[3], 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[4], 4, 1, 1, 0, 0, 0, 0, 1));
        run_table("illegal");
        drain();

        // Skip: pulse, FAULT, resync; then illegal while tracking and recover
        do_reset("reset_skip");
        tbl.delete();
        tbl.push_back(mk(gly[2], 2, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[5], 5, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(gly[6], 6, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[7], 7, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(7'h01, 7, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(7'h01, 7, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(gly[8], 8, 1, 0, 0, 0, 0, 0, 1));
        run_table("skip");
        drain();

        // Reset mid-operation at digit 7, then fresh acquisition of 4
        do_reset("reset_mid_pre");
        tbl.delete();
        tbl.push_back(mk(gly[5], 5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[6], 6, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(gly[7], 7, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(gly[7], 7, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(gly[7], 7, 1, 1, 0, 0, 0, 0, 2));
        run_table("mid_pre");
        do_reset("reset_mid");
        tbl.delete();
        tbl.push_back(mk(gly[4], 4, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(gly[3], 3, 1, 0, 1, 0, 0, 0, 1));
        run_table("mid_post");
        drain();

        // Step counter saturates at 255 and never wraps
        do_reset("reset_sat");
        tbl.delete();
        tbl.push_back(mk(gly[0], 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 260; k++)
            tbl.push_back(mk(gly[k % 10], k % 10, 1, 1, 0, 0, 0, 0, (k > 255) ? 255 : k));
        run_table("saturate");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seg7_monitor

`default_nettype wire
